move_wide_unit: RTL
===================

// Module: move_wide_unit
// PURPOSE
//  Pipelined move-wide execute unit for MOVZ / MOVN / MOVK (AArch64 wide-immediate moves).
//  Generalises lane insertion to DATA_W/IMM_W lanes with a hw lane selector.
//  Adds 32-bit (sf=0) mode, illegal-encoding detection and a valid/ready handshake on both sides.
//  Adds internal forwarding so back-to-back MOVK chains to one register build a constant correctly.
//  Sits in the execute stage between the decode/register-read and writeback.
// PARAMETERS
//  DATA_W  64  result/register width; must be a multiple of IMM_W
//  IMM_W   16  immediate (lane) width
//  LANES   DATA_W/IMM_W (derived, localparam); must be a power of 2, >=2
//  HW_W    $clog2(LANES) (derived, localparam) lane-selector width
//  REG_W   5   destination register address width; address 2**REG_W-1 is the zero register (XZR)
// PORTS
//  clk          in   1       clock, rising edge
//  reset_n      in   1       asynchronous active-low reset
//  flush        in   1       synchronous pipeline flush
//  in_valid     in   1       request valid
//  in_ready     out  1       unit can accept a request this cycle
//  in_op        in   2       00 MOVZ, 01 MOVN, 10 MOVK, 11 illegal
//  in_sf        in   1       1 = DATA_W-bit op, 0 = DATA_W/2-bit op
//  in_hw        in   HW_W    target lane; shift = hw*IMM_W
//  in_imm       in   IMM_W   immediate
//  in_rd        in   REG_W   destination register
//  in_rd_val    in   DATA_W  register-file value of rd (used by MOVK only)
//  out_valid    out  1       result valid
//  out_ready    in   1       consumer accepts result
//  out_result   out  DATA_W  computed value
//  out_rd       out  REG_W   destination register
//  out_err      out  1       illegal encoding; out_result forced to 0
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - All valids clear; out_valid=0, out_result=0, out_rd=0, out_err=0.
//   - Retire register cleared.
//   - in_ready=1 once reset deasserts.
//  Pipeline: two stages, S1 (capture) and S2 (compute/output); latency 2 cycles with no stall.
//   - Full throughput: 1 request per cycle.
//   - S2 loads when !s2_valid || out_ready.
//   - S1 advances when S2 loads.
//   - in_ready = !flush && (!s1_valid || S2 loads); accept on in_valid && in_ready.
//   - Outputs are registered and held stable while out_valid && !out_ready.
//  Compute (in S1 -> S2 load), lane field L = [hw*IMM_W +: IMM_W]:
//   - MOVZ: result = 0; result[L] = imm.
//   - MOVN: result = ~(imm << hw*IMM_W) over DATA_W.
//   - MOVK: result = base; result[L] = imm.
//   - sf=0: result[DATA_W-1:DATA_W/2] forced to 0 after the op; this includes MOVN.
//  Illegal: op==11, or sf=0 && hw>=LANES/2.
//   - out_err=1, out_result=0, out_rd passes through.
//   - Error results do not update the retire register or forwarding.
//  MOVK base selection, priority high->low:
//   - rd==XZR -> base = 0.
//   - S2 holds a valid, non-error result for same rd -> S2 out_result.
//   - Retire register valid with same rd -> retire value.
//   - Otherwise -> in_rd_val captured in S1.
//  Retire register:
//   - On out_valid && out_ready && !out_err, loads {rd, result}.
//   - Covers the 1-cycle writeback gap.
//   - When S2 is loading the same rd this cycle, the newer S2 value wins.
//  Flush: at the next edge clears s1_valid, s2_valid and retire-register valid; in_ready=0 during flush.
//  Simultaneous events:
//   - flush beats accept and handshake.
//   - Async reset mid-transaction drops all in-flight requests; no partial output.
// TESTING
//  1. MOVZ hw=2 imm=16'hBEEF sf=1 -> out_result=64'h0000_BEEF_0000_0000 two cycles after accept.
//  2. MOVN hw=0 imm=16'h0001 sf=0 -> out_result=64'h0000_0000_FFFF_FFFE.
//  3. Back-to-back MOVZ x3 (hw0, 16'h1111), then MOVK x3 hw1/hw2/hw3 with 2222/3333/4444 and stale in_rd_val=0
//     -> final out_result=64'h4444_3333_2222_1111.
//  4. out_ready=0 for 5 cycles with 3 requests sent -> in_ready drops after 2 accepted;
//     outputs stable, in order, none lost.
//  5. op=11, then sf=0 hw=3 -> out_err=1, out_result=0; a following MOVK to same rd uses in_rd_val.
//  6. Flush with both stages full, then reset_n pulse mid-stream -> no out_valid from flushed items;
//     all outputs 0 asynchronously.

Source files
------------

// File: rtl/move_wide_unit.sv
// move_wide_unit: two-stage execute unit for MOVZ / MOVN / MOVK wide-immediate moves.
// S1 captures the request; S2 holds the computed, registered result.
// MOVK bases are forwarded from S2 or from a one-entry retire register so that
// back-to-back insert chains to one register build the full constant.
module move_wide_unit #(
  parameter int DATA_W = 64,
  parameter int IMM_W  = 16,
  parameter int REG_W  = 5,
  localparam int LANES = DATA_W / IMM_W,
  localparam int HW_W  = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic              in_sf,
  input  logic [HW_W-1:0]   in_hw,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_rd_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_err
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [REG_W-1:0] XZR = {REG_W{1'b1}};

  logic              s1_valid;
  logic [1:0]        s1_op;
  logic              s1_sf;
  logic [HW_W-1:0]   s1_hw;
  logic [IMM_W-1:0]  s1_imm;
  logic [REG_W-1:0]  s1_rd;
  logic [DATA_W-1:0] s1_rd_val;

  logic              ret_valid;
  logic [REG_W-1:0]  ret_rd;
  logic [DATA_W-1:0] ret_val;

  logic              s2_load;
  logic              out_fire;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] imm_sh;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] s1_result;
  logic              s1_illegal;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_load);
  // A handshake coinciding with a flush is discarded, so it must not retire.
  assign out_fire = out_valid && out_ready && !flush;

  // Result computation for the request sitting in S1, including MOVK base forwarding.
  always_comb begin
    shamt      = SH_W'(s1_hw) * SH_W'(IMM_W);
    imm_sh     = {{(DATA_W-IMM_W){1'b0}}, s1_imm} << shamt;
    lane_mask  = {{(DATA_W-IMM_W){1'b0}}, {IMM_W{1'b1}}} << shamt;
    s1_illegal = (s1_op == 2'b11) || (!s1_sf && (s1_hw >= HW_W'(LANES/2)));

    if (s1_rd == XZR)
      base = '0;
    else if (out_valid && !out_err && (out_rd == s1_rd))
      base = out_result;
    else if (ret_valid && (ret_rd == s1_rd))
      base = ret_val;
    else
      base = s1_rd_val;

    case (s1_op)
      2'b00:   s1_result = imm_sh;
      2'b01:   s1_result = ~imm_sh;
      2'b10:   s1_result = (base & ~lane_mask) | imm_sh;
      default: s1_result = '0;
    endcase
    if (!s1_sf)
      s1_result[DATA_W-1:DATA_W/2] = '0;
    if (s1_illegal)
      s1_result = '0;
  end

  // S1 capture stage: accepts a new request whenever it is empty or draining into S2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_sf     <= 1'b0;
      s1_hw     <= '0;
      s1_imm    <= '0;
      s1_rd     <= '0;
      s1_rd_val <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op     <= in_op;
        s1_sf     <= in_sf;
        s1_hw     <= in_hw;
        s1_imm    <= in_imm;
        s1_rd     <= in_rd;
        s1_rd_val <= in_rd_val;
      end
    end
  end

  // S2 output stage: registered result, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_err    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= s1_result;
        out_rd     <= s1_rd;
        out_err    <= s1_illegal;
      end
    end
  end

  // Retire register: remembers the last accepted good result across the writeback gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_valid <= 1'b0;
      ret_rd    <= '0;
      ret_val   <= '0;
    end else if (flush) begin
      ret_valid <= 1'b0;
    end else if (out_fire && !out_err) begin
      ret_valid <= 1'b1;
      ret_rd    <= out_rd;
      ret_val   <= out_result;
    end
  end

endmodule
